// File: rtl/signal_phase_scheduler_if.sv
// Bundle between the phase scheduler, the sensor front ends and the lamp driver.
// The master side drives timing, density and emergency inputs; the slave side answers with grant/stage.
interface signal_phase_scheduler_if;
  logic       tick;
  logic [7:0] density;
  logic [3:0] emerg_req;
  logic [3:0] grant;
  logic [1:0] stage;
  logic       emerg_active;
  logic       phase_done;

  modport master (
    output tick, density, emerg_req,
    input  grant, stage, emerg_active, phase_done
  );

  modport slave (
    input  tick, density, emerg_req,
    output grant, stage, emerg_active, phase_done
  );
endinterface

// File: rtl/signal_phase_scheduler.sv
// Four-approach intersection phase scheduler: density-weighted round-robin greens,
// yellow/all-red clearance, and emergency hold, with all timing advanced by a slow tick strobe.
module signal_phase_scheduler #(
  parameter int GREEN_BASE = 4,
  parameter int GREEN_STEP = 3,
  parameter int YELLOW_T   = 2,
  parameter int ALLRED_T   = 1,
  parameter int SKIP_EMPTY = 1
) (
  input logic                     clk,
  input logic                     reset,
  signal_phase_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    ALL_RED    = 2'd0,
    GREEN      = 2'd1,
    YELLOW     = 2'd2,
    EMERG_HOLD = 2'd3
  } state_t;

  localparam logic [7:0] GB = 8'(GREEN_BASE);
  localparam logic [7:0] GS = 8'(GREEN_STEP);
  localparam logic [7:0] YT = 8'(YELLOW_T);
  localparam logic [7:0] AT = 8'(ALLRED_T);

  state_t     state;
  logic [7:0] timer;
  logic [1:0] rr_ptr;
  logic [1:0] sel;
  logic [1:0] emerg_sel;
  logic       pend_emerg;

  logic       any_emerg;
  logic       expire;
  logic [1:0] emerg_pick;
  logic [1:0] rr_pick;
  logic [1:0] scan_idx;
  logic [1:0] pick_dens;
  logic [7:0] green_load;

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Lowest-index request wins, so the loop runs downward and the last hit is the answer.
  always_comb begin
    emerg_pick = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (bus.emerg_req[i]) emerg_pick = 2'(i);
    end
  end

  // Scan from rr_ptr onward for an occupied approach; falls back to rr_ptr when all are empty.
  always_comb begin
    rr_pick  = rr_ptr;
    scan_idx = rr_ptr;
    if (SKIP_EMPTY != 0) begin
      for (int k = 3; k >= 0; k--) begin
        scan_idx = rr_ptr + 2'(k);
        if (bus.density[{scan_idx, 1'b0} +: 2] != 2'd0) rr_pick = scan_idx;
      end
    end
  end

  assign any_emerg  = (bus.emerg_req != 4'd0);
  assign expire     = bus.tick && (timer == 8'd1);
  assign pick_dens  = bus.density[{rr_pick, 1'b0} +: 2];
  assign green_load = GB + GS * {6'd0, pick_dens};

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ALL_RED;
      timer            <= AT;
      rr_ptr           <= 2'd0;
      sel              <= 2'd0;
      emerg_sel        <= 2'd0;
      pend_emerg       <= 1'b0;
      bus.grant        <= 4'd0;
      bus.stage        <= 2'd0;
      bus.emerg_active <= 1'b0;
      bus.phase_done   <= 1'b0;
    end else begin
      bus.phase_done <= 1'b0;
      case (state)
        ALL_RED: begin
          if (expire) begin
            if (pend_emerg || any_emerg) begin
              state            <= EMERG_HOLD;
              pend_emerg       <= 1'b0;
              bus.stage        <= 2'd1;
              bus.emerg_active <= 1'b1;
              if (any_emerg) begin
                emerg_sel <= emerg_pick;
                bus.grant <= onehot(emerg_pick);
              end else begin
                bus.grant <= onehot(emerg_sel);
              end
            end else begin
              state     <= GREEN;
              sel       <= rr_pick;
              rr_ptr    <= rr_pick + 2'd1;
              timer     <= green_load;
              bus.grant <= onehot(rr_pick);
              bus.stage <= 2'd1;
            end
          end else if (bus.tick) begin
            timer <= timer - 8'd1;
          end
        end

        // An emergency request outranks a coincident green expiry.
        GREEN: begin
          if (any_emerg) begin
            if (emerg_pick == sel) begin
              state            <= EMERG_HOLD;
              emerg_sel        <= sel;
              bus.emerg_active <= 1'b1;
            end else begin
              state      <= YELLOW;
              timer      <= YT;
              pend_emerg <= 1'b1;
              emerg_sel  <= emerg_pick;
              bus.stage  <= 2'd2;
            end
          end else if (expire) begin
            state     <= YELLOW;
            timer     <= YT;
            bus.stage <= 2'd2;
          end else if (bus.tick) begin
            timer <= timer - 8'd1;
          end
        end

        YELLOW: begin
          if (expire) begin
            state          <= ALL_RED;
            timer          <= AT;
            bus.grant      <= 4'd0;
            bus.stage      <= 2'd0;
            bus.phase_done <= 1'b1;
          end else if (bus.tick) begin
            timer <= timer - 8'd1;
          end
        end

        EMERG_HOLD: begin
          if (!bus.emerg_req[emerg_sel]) begin
            state            <= YELLOW;
            sel              <= emerg_sel;
            timer            <= YT;
            rr_ptr           <= emerg_sel + 2'd1;
            bus.stage        <= 2'd2;
            bus.emerg_active <= 1'b0;
          end
        end

        default: begin
          state <= ALL_RED;
          timer <= AT;
        end
      endcase
    end
  end

endmodule
